// File: rtl/spi_flash_arbiter.sv
// rtl/spi_flash_arbiter.sv - two-port round-robin read arbiter in front of a SPI flash controller
module spi_flash_arbiter #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [23:0] addr0,
    input  logic [23:0] addr1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic [23:0] flash_addr,
    output logic        flash_strobe,
    input  logic [31:0] flash_data,
    input  logic        flash_done,
    output logic        busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY    = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    // Wide enough to count 0 .. TIMEOUT_CYCLES-1.
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state;
    logic          grant;
    logic          last_grant;
    logic [CW-1:0] count;
    logic          pick;
    logic          finish;

    // Round-robin choice: a lone requester wins, a contest goes to the port not served last.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last_grant;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    // Transaction ends on flash_done, or on the final timeout cycle; flash_done wins a tie.
    assign finish = flash_done || (count == LAST_COUNT);

    assign busy = (state != IDLE);

    // Arbitration state machine, flash handshake and per-port result registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            count        <= '0;
            flash_addr   <= 24'h000000;
            flash_strobe <= 1'b0;
            rdata0       <= 32'h0000_0000;
            rdata1       <= 32'h0000_0000;
            done0        <= 1'b0;
            done1        <= 1'b0;
            err0         <= 1'b0;
            err1         <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant        <= pick;
                        last_grant   <= pick;
                        flash_addr   <= pick ? addr1 : addr0;
                        flash_strobe <= 1'b1;
                        count        <= '0;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (finish) begin
                        flash_strobe <= 1'b0;
                        state        <= RELEASE;
                        if (grant) begin
                            done1  <= 1'b1;
                            err1   <= ~flash_done;
                            rdata1 <= flash_done ? flash_data : 32'hFFFF_FFFF;
                        end else begin
                            done0  <= 1'b1;
                            err0   <= ~flash_done;
                            rdata0 <= flash_done ? flash_data : 32'hFFFF_FFFF;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb/tb_spi_flash_arbiter.sv - directed self-checking bench for spi_flash_arbiter
module tb_spi_flash_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default timeout, used for normal traffic.
    logic        a_reset_n, a_req0, a_req1, a_flash_done;
    logic [23:0] a_addr0, a_addr1;
    logic [31:0] a_flash_data;
    logic [31:0] a_rdata0, a_rdata1;
    logic        a_done0, a_done1, a_err0, a_err1, a_strobe, a_busy;
    logic [23:0] a_flash_addr;

    // Instance B: short timeout for the timeout and tie cases.
    logic        b_reset_n, b_req0, b_req1, b_flash_done;
    logic [23:0] b_addr0, b_addr1;
    logic [31:0] b_flash_data;
    logic [31:0] b_rdata0, b_rdata1;
    logic        b_done0, b_done1, b_err0, b_err1, b_strobe, b_busy;
    logic [23:0] b_flash_addr;

    spi_flash_arbiter dut_a (
        .clk(clk), .reset_n(a_reset_n), .req0(a_req0), .req1(a_req1),
        .addr0(a_addr0), .addr1(a_addr1), .rdata0(a_rdata0), .rdata1(a_rdata1),
        .done0(a_done0), .done1(a_done1), .err0(a_err0), .err1(a_err1),
        .flash_addr(a_flash_addr), .flash_strobe(a_strobe), .flash_data(a_flash_data),
        .flash_done(a_flash_done), .busy(a_busy)
    );

    spi_flash_arbiter #(.TIMEOUT_CYCLES(16)) dut_b (
        .clk(clk), .reset_n(b_reset_n), .req0(b_req0), .req1(b_req1),
        .addr0(b_addr0), .addr1(b_addr1), .rdata0(b_rdata0), .rdata1(b_rdata1),
        .done0(b_done0), .done1(b_done1), .err0(b_err0), .err1(b_err1),
        .flash_addr(b_flash_addr), .flash_strobe(b_strobe), .flash_data(b_flash_data),
        .flash_done(b_flash_done), .busy(b_busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r0;
        logic        r1;
        logic [23:0] a0;
        logic [23:0] a1;
        int          lat;
        logic [31:0] data;
        logic        port;
    } vec_t;

    vec_t vecs[6];
    logic [31:0] exp_rd0, exp_rd1;
    logic [23:0] exp_addr;
    int n;

    initial begin
        // Round-robin pointer starts at 1, so each contest alternates from port 0.
        vecs[0] = '{1'b1, 1'b0, 24'h000005, 24'h000000, 40, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 24'h000000, 24'h123456, 3,  32'hCAFEF00D, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 24'h0000AA, 24'h0000BB, 0,  32'h11111111, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 24'hABCDEF, 24'hFEDCBA, 5,  32'h22222222, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 24'h000000, 24'h00F00F, 2,  32'h33333333, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 24'h0A0A0A, 24'h0B0B0B, 1,  32'h44444444, 1'b0};

        a_reset_n = 1'b0; a_req0 = 0; a_req1 = 0; a_addr0 = 0; a_addr1 = 0;
        a_flash_done = 0; a_flash_data = 0;
        b_reset_n = 1'b0; b_req0 = 0; b_req1 = 0; b_addr0 = 0; b_addr1 = 0;
        b_flash_done = 0; b_flash_data = 0;
        tick();
        tick();
        a_reset_n = 1'b1;
        b_reset_n = 1'b1;

        chk("reset_strobe", {31'd0, a_strobe}, 32'd0);
        chk("reset_busy", {31'd0, a_busy}, 32'd0);
        chk("reset_addr", {8'd0, a_flash_addr}, 32'd0);
        chk("reset_rdata0", a_rdata0, 32'd0);
        chk("reset_rdata1", a_rdata1, 32'd0);
        chk("reset_done_err", {28'd0, a_done0, a_done1, a_err0, a_err1}, 32'd0);

        // Table-driven single transactions on instance A.
        exp_rd0 = 32'd0;
        exp_rd1 = 32'd0;
        for (int i = 0; i < 6; i++) begin
            a_req0 = vecs[i].r0; a_req1 = vecs[i].r1;
            a_addr0 = vecs[i].a0; a_addr1 = vecs[i].a1;
            exp_addr = vecs[i].port ? vecs[i].a1 : vecs[i].a0;
            tick();
            chk($sformatf("v%0d_strobe_up", i), {31'd0, a_strobe}, 32'd1);
            chk($sformatf("v%0d_addr", i), {8'd0, a_flash_addr}, {8'd0, exp_addr});
            chk($sformatf("v%0d_busy", i), {31'd0, a_busy}, 32'd1);
            repeat (vecs[i].lat) tick();
            chk($sformatf("v%0d_strobe_held", i), {7'd0, a_strobe, a_flash_addr}, {7'd0, 1'b1, exp_addr});
            a_flash_data = vecs[i].data;
            a_flash_done = 1'b1;
            tick();
            a_flash_done = 1'b0;
            a_req0 = 1'b0;
            a_req1 = 1'b0;
            if (vecs[i].port) exp_rd1 = vecs[i].data;
            else exp_rd0 = vecs[i].data;
            chk($sformatf("v%0d_done", i), {30'd0, a_done1, a_done0},
                vecs[i].port ? 32'd2 : 32'd1);
            chk($sformatf("v%0d_rdata0", i), a_rdata0, exp_rd0);
            chk($sformatf("v%0d_rdata1", i), a_rdata1, exp_rd1);
            chk($sformatf("v%0d_err", i), {30'd0, a_err1, a_err0}, 32'd0);
            chk($sformatf("v%0d_strobe_down", i), {31'd0, a_strobe}, 32'd0);
            tick();
            chk($sformatf("v%0d_done_one_cycle", i), {30'd0, a_done1, a_done0}, 32'd0);
            chk($sformatf("v%0d_idle", i), {30'd0, a_busy, a_strobe}, 32'd0);
        end

        // Contention with both requests held: 0, 1, 0 with a strobe gap between grants.
        a_reset_n = 1'b0;
        tick();
        a_reset_n = 1'b1;
        a_req0 = 1'b1; a_req1 = 1'b1;
        a_addr0 = 24'h000100; a_addr1 = 24'h000200;
        tick();
        chk("cont_first_addr", {8'd0, a_flash_addr}, 32'h00000100);
        for (int k = 0; k < 3; k++) begin
            repeat (2) tick();
            a_flash_data = 32'hC0DE0000 + k;
            a_flash_done = 1'b1;
            tick();
            a_flash_done = 1'b0;
            if (k == 2) begin
                a_req0 = 1'b0;
                a_req1 = 1'b0;
            end
            chk($sformatf("cont%0d_done", k), {30'd0, a_done1, a_done0},
                (k == 1) ? 32'd2 : 32'd1);
            chk($sformatf("cont%0d_low_m", k), {31'd0, a_strobe}, 32'd0);
            tick();
            chk($sformatf("cont%0d_low_m1", k), {31'd0, a_strobe}, 32'd0);
            tick();
            if (k < 2) begin
                chk($sformatf("cont%0d_next_grant", k), {7'd0, a_strobe, a_flash_addr},
                    {7'd0, 1'b1, (k == 0) ? 24'h000200 : 24'h000100});
            end else begin
                chk("cont_end_idle", {31'd0, a_strobe}, 32'd0);
            end
        end

        // Requester withdraws two cycles into BUSY; transaction still completes.
        a_req1 = 1'b1; a_addr1 = 24'h00ABCD;
        tick();
        chk("wd_strobe", {7'd0, a_strobe, a_flash_addr}, {7'd0, 1'b1, 24'h00ABCD});
        repeat (2) tick();
        a_req1 = 1'b0;
        repeat (2) tick();
        chk("wd_held", {7'd0, a_strobe, a_flash_addr}, {7'd0, 1'b1, 24'h00ABCD});
        a_flash_data = 32'h5A5A5A5A;
        a_flash_done = 1'b1;
        tick();
        a_flash_done = 1'b0;
        chk("wd_done1", {31'd0, a_done1}, 32'd1);
        chk("wd_rdata1", a_rdata1, 32'h5A5A5A5A);
        chk("wd_err1", {31'd0, a_err1}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("wd_no_restrobe%0d", k), {30'd0, a_strobe, a_done1}, 32'd0);
        end

        // Reset mid-BUSY: serve port 0 first so only the reset restores the pointer to 1.
        a_req0 = 1'b1; a_addr0 = 24'h000777;
        tick();
        a_flash_data = 32'h77777777;
        a_flash_done = 1'b1;
        tick();
        a_flash_done = 1'b0;
        a_req0 = 1'b0;
        tick();
        tick();
        a_req0 = 1'b1; a_addr0 = 24'h000888;
        tick();
        chk("rst_txn_started", {31'd0, a_strobe}, 32'd1);
        repeat (2) tick();
        a_reset_n = 1'b0;
        a_req0 = 1'b0;
        tick();
        a_reset_n = 1'b1;
        chk("rst_strobe_busy", {30'd0, a_strobe, a_busy}, 32'd0);
        chk("rst_no_done", {30'd0, a_done1, a_done0}, 32'd0);
        chk("rst_rdata0", a_rdata0, 32'd0);
        a_flash_done = 1'b1;
        tick();
        a_flash_done = 1'b0;
        chk("rst_done_ignored", {29'd0, a_busy, a_done1, a_done0}, 32'd0);
        a_req0 = 1'b1; a_req1 = 1'b1;
        a_addr0 = 24'h000888; a_addr1 = 24'h000999;
        tick();
        chk("rst_port0_wins", {7'd0, a_strobe, a_flash_addr}, {7'd0, 1'b1, 24'h000888});
        a_flash_data = 32'h88888888;
        a_flash_done = 1'b1;
        tick();
        a_flash_done = 1'b0;
        a_req0 = 1'b0; a_req1 = 1'b0;
        chk("rst_after_done0", {31'd0, a_done0}, 32'd1);
        chk("rst_after_rdata0", a_rdata0, 32'h88888888);

        // Timeout on instance B with flash_done never arriving.
        b_req1 = 1'b1; b_addr1 = 24'h000042;
        tick();
        chk("to_strobe", {7'd0, b_strobe, b_flash_addr}, {7'd0, 1'b1, 24'h000042});
        b_req1 = 1'b0;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (b_done1 || b_done0) begin
                n = k;
                break;
            end
        end
        chk("to_latency", n, 16);
        chk("to_flags", {29'd0, b_done0, b_done1, b_err1}, 32'd3);
        chk("to_rdata1", b_rdata1, 32'hFFFFFFFF);
        chk("to_rdata0_held", b_rdata0, 32'd0);
        chk("to_strobe_down", {31'd0, b_strobe}, 32'd0);
        tick();
        chk("to_err_holds", {30'd0, b_done1, b_err1}, 32'd1);
        tick();

        // flash_done on the final timeout cycle counts as a normal completion.
        b_req1 = 1'b1; b_addr1 = 24'h000043;
        tick();
        b_req1 = 1'b0;
        chk("tie_err_still_held", {31'd0, b_err1}, 32'd1);
        repeat (15) tick();
        chk("tie_not_yet_done", {30'd0, b_done1, b_strobe}, 32'd1);
        b_flash_data = 32'h0BADCAFE;
        b_flash_done = 1'b1;
        tick();
        b_flash_done = 1'b0;
        chk("tie_done1", {31'd0, b_done1}, 32'd1);
        chk("tie_err1", {31'd0, b_err1}, 32'd0);
        chk("tie_rdata1", b_rdata1, 32'h0BADCAFE);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
